// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the uart_tx byte channel between two burst requesters.
// A grant lasts until the requester's `last` transfer or until it idles for TIMEOUT_CYCLES.
module uart_tx_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_data_vld_i,
  input  logic       req0_data_last_i,
  output logic       req0_data_rdy_o,
  input  logic [7:0] req1_data_i,
  input  logic       req1_data_vld_i,
  input  logic       req1_data_last_i,
  output logic       req1_data_rdy_o,
  output logic [7:0] uart_tx_data_o,
  output logic       uart_tx_data_vld_o,
  input  logic       uart_tx_data_rdy_i,
  output logic [1:0] arb_gnt_o,
  output logic       arb_timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_vld, sel_last, xfer_last, timeout;

  // Pass-through mux for whichever requester owns the channel.
  always_comb begin
    sel_vld            = 1'b0;
    sel_last           = 1'b0;
    uart_tx_data_o     = '0;
    uart_tx_data_vld_o = 1'b0;
    req0_data_rdy_o    = 1'b0;
    req1_data_rdy_o    = 1'b0;
    unique case (state_q)
      StGnt0: begin
        sel_vld            = req0_data_vld_i;
        sel_last           = req0_data_last_i;
        uart_tx_data_o     = req0_data_i;
        uart_tx_data_vld_o = req0_data_vld_i;
        req0_data_rdy_o    = uart_tx_data_rdy_i;
      end
      StGnt1: begin
        sel_vld            = req1_data_vld_i;
        sel_last           = req1_data_last_i;
        uart_tx_data_o     = req1_data_i;
        uart_tx_data_vld_o = req1_data_vld_i;
        req1_data_rdy_o    = uart_tx_data_rdy_i;
      end
      default: ;
    endcase
  end

  assign timeout   = (state_q != StIdle) && !sel_vld && (cnt_q == CntLast);
  assign xfer_last = sel_vld && uart_tx_data_rdy_i && sel_last;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = '0;
    if (state_q == StIdle) begin
      if (req0_data_vld_i && req1_data_vld_i) begin
        state_d = last_gnt_q ? StGnt0 : StGnt1;
      end else if (req0_data_vld_i) begin
        state_d = StGnt0;
      end else if (req1_data_vld_i) begin
        state_d = StGnt1;
      end
    end else if (xfer_last || timeout) begin
      state_d    = StIdle;
      last_gnt_d = (state_q == StGnt1);
    end else if (!sel_vld) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign arb_gnt_o     = {state_q == StGnt1, state_q == StGnt0};
  assign arb_timeout_o = timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: cycle model of owner/round-robin/idle-time rules
// plus directed scenarios with literal expectations on the delivered byte stream.
module tb_uart_tx_arb;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_vld = 1'b0, req1_vld = 1'b0;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_rdy, req1_rdy;
  logic [7:0] uart_data;
  logic       uart_vld;
  logic       uart_rdy;
  logic [1:0] arb_gnt;
  logic       arb_timeout;

  uart_tx_arb #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .req0_data_i        (req0_data),
    .req0_data_vld_i    (req0_vld),
    .req0_data_last_i   (req0_last),
    .req0_data_rdy_o    (req0_rdy),
    .req1_data_i        (req1_data),
    .req1_data_vld_i    (req1_vld),
    .req1_data_last_i   (req1_last),
    .req1_data_rdy_o    (req1_rdy),
    .uart_tx_data_o     (uart_data),
    .uart_tx_data_vld_o (uart_vld),
    .uart_tx_data_rdy_i (uart_rdy),
    .arb_gnt_o          (arb_gnt),
    .arb_timeout_o      (arb_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request queues: {last, data}; each driver presents its head until accepted.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit acc0, acc1;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    if (acc0 && q0.size() != 0) void'(q0.pop_front());
    if (q0.size() != 0) begin
      req0_vld = 1'b1;
      {req0_last, req0_data} = q0[0];
    end else begin
      req0_vld = 1'b0; req0_last = 1'b0; req0_data = '0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (acc1 && q1.size() != 0) void'(q1.pop_front());
    if (q1.size() != 0) begin
      req1_vld = 1'b1;
      {req1_last, req1_data} = q1[0];
    end else begin
      req1_vld = 1'b0; req1_last = 1'b0; req1_data = '0;
    end
  end

  // Model: who owns the channel, who was served last, how long the owner has been idle.
  int m_own = -1;
  int m_last = 1;
  int m_low = 0;

  logic [7:0] got_data[$];
  logic [1:0] got_gnt[$];
  int         got_cyc[$];
  int         to_cnt = 0;
  int         to_cyc = 0;

  logic       p_ok = 1'b0;
  logic       p_vld0, p_rdy0, p_last0, p_vld1, p_rdy1, p_last1;
  logic [7:0] p_d0, p_d1;

  always @(negedge clk) begin
    logic       sv, sl, et, er0, er1;
    logic [7:0] sd;
    logic [1:0] eg;
    acc0 = rst_n && req0_vld && req0_rdy;
    acc1 = rst_n && req1_vld && req1_rdy;
    if (!rst_n) begin
      m_own = -1; m_last = 1; m_low = 0;
      chk("rst_gnt", 32'(arb_gnt), 0);
      chk("rst_vld", 32'(uart_vld), 0);
      chk("rst_timeout", 32'(arb_timeout), 0);
    end else begin
      sv = (m_own == 0) ? req0_vld  : (m_own == 1) ? req1_vld  : 1'b0;
      sl = (m_own == 0) ? req0_last : (m_own == 1) ? req1_last : 1'b0;
      sd = (m_own == 0) ? req0_data : (m_own == 1) ? req1_data : 8'h00;
      eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
      er0 = (m_own == 0) && uart_rdy;
      er1 = (m_own == 1) && uart_rdy;
      et = (m_own >= 0) && !sv && (m_low + 1 == T);
      chk("gnt", 32'(arb_gnt), 32'(eg));
      chk("uart_vld", 32'(uart_vld), 32'(sv));
      chk("uart_data", 32'(uart_data), 32'(sd));
      chk("rdy0", 32'(req0_rdy), 32'(er0));
      chk("rdy1", 32'(req1_rdy), 32'(er1));
      chk("timeout", 32'(arb_timeout), 32'(et));
      if (uart_vld && uart_rdy) begin
        got_data.push_back(uart_data);
        got_gnt.push_back(arb_gnt);
        got_cyc.push_back(cyc);
      end
      if (arb_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (m_own < 0) begin
        if (req0_vld && req1_vld) m_own = (m_last == 0) ? 1 : 0;
        else if (req0_vld) m_own = 0;
        else if (req1_vld) m_own = 1;
        m_low = 0;
      end else if ((sv && uart_rdy && sl) || et) begin
        m_last = m_own;
        m_own = -1;
      end else if (sv) begin
        m_low = 0;
      end else begin
        m_low++;
      end
    end
    // Requesters must hold a stalled byte.
    if (rst_n && p_ok) begin
      if (p_vld0 && !p_rdy0)
        assert (req0_vld && req0_data == p_d0 && req0_last == p_last0)
          else $error("requester 0 dropped a stalled byte");
      if (p_vld1 && !p_rdy1)
        assert (req1_vld && req1_data == p_d1 && req1_last == p_last1)
          else $error("requester 1 dropped a stalled byte");
    end
    p_ok = rst_n;
    p_vld0 = req0_vld; p_rdy0 = req0_rdy; p_d0 = req0_data; p_last0 = req0_last;
    p_vld1 = req1_vld; p_rdy1 = req1_rdy; p_d1 = req1_data; p_last1 = req1_last;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_gnt.delete();
    got_cyc.delete();
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_count"}, 32'(got_data.size() >= n), 1);
  endtask

  task automatic chk_got(input string name, input int i, input logic [7:0] d, input logic [1:0] g);
    if (i < got_data.size()) begin
      chk({name, "_data"}, 32'(got_data[i]), 32'(d));
      chk({name, "_gnt"}, 32'(got_gnt[i]), 32'(g));
    end else begin
      chk({name, "_missing"}, 32'(got_data.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_gap(input string name, input int i, input int gap);
    if (i < got_cyc.size()) chk(name, 32'(got_cyc[i] - got_cyc[i-1]), 32'(gap));
    else chk({name, "_missing"}, 32'(got_cyc.size()), 32'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] rr_exp[8];

  initial begin
    rst_n = 1'b0;
    uart_rdy = 1'b1;
    #3;
    chk("reset_gnt", 32'(arb_gnt), 0);
    chk("reset_data", 32'(uart_data), 0);
    chk("reset_rdy0", 32'(req0_rdy), 0);
    chk("reset_rdy1", 32'(req1_rdy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_gnt", 32'(arb_gnt), 0);

    // Burst ownership: req1 waits behind a 4-byte req0 burst.
    clear_got();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h12});
    q0.push_back({1'b0, 8'h13}); q0.push_back({1'b1, 8'h14});
    repeat (2) tick();
    q1.push_back({1'b1, 8'hA5});
    wait_got("burst", 5, 40);
    chk_got("burst0", 0, 8'h11, 2'b01);
    chk_got("burst1", 1, 8'h12, 2'b01);
    chk_got("burst2", 2, 8'h13, 2'b01);
    chk_got("burst3", 3, 8'h14, 2'b01);
    chk_got("burst4", 4, 8'hA5, 2'b10);
    chk_gap("burst_gap1", 1, 1);
    chk_gap("burst_gap3", 3, 1);
    chk_gap("burst_switch", 4, 2);
    repeat (3) tick();

    // Round-robin with single-byte bursts; req0 wins the first tie.
    clear_got();
    rr_exp = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 8'(i)});
      q1.push_back({1'b1, 8'(8'h10 + i)});
    end
    wait_got("rr", 8, 60);
    for (int i = 0; i < 8; i++) chk_got("rr", i, rr_exp[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    chk_gap("rr_gap", 1, 2);
    repeat (3) tick();

    // Back-pressure: 107 stalled cycles per byte of a req1 burst.
    clear_got();
    uart_rdy = 1'b0;
    q1.push_back({1'b0, 8'h21}); q1.push_back({1'b0, 8'h22}); q1.push_back({1'b1, 8'h23});
    for (int b = 0; b < 3; b++) begin
      repeat (107) tick();
      uart_rdy = 1'b1;
      tick();
      uart_rdy = 1'b0;
    end
    uart_rdy = 1'b1;
    repeat (3) tick();
    chk("bp_count", 32'(got_data.size()), 3);
    chk_got("bp0", 0, 8'h21, 2'b10);
    chk_got("bp1", 1, 8'h22, 2'b10);
    chk_got("bp2", 2, 8'h23, 2'b10);
    chk_gap("bp_gap1", 1, 108);
    chk_gap("bp_gap2", 2, 108);

    // Timeout: req0 sends one byte without last, req1 pending behind it.
    clear_got();
    to_cnt = 0;
    q0.push_back({1'b0, 8'h31});
    q1.push_back({1'b1, 8'h41});
    wait_got("to", 2, 40);
    chk("to_pulses", 32'(to_cnt), 1);
    if (got_cyc.size() != 0) chk("to_delay", 32'(to_cyc - got_cyc[0]), 8);
    else chk("to_delay_missing", 32'(got_cyc.size()), 1);
    chk_got("to0", 0, 8'h31, 2'b01);
    chk_got("to1", 1, 8'h41, 2'b10);
    chk_gap("to_gap", 1, 10);
    repeat (3) tick();

    // Asynchronous reset in the middle of a req1 burst.
    clear_got();
    q1.push_back({1'b0, 8'h51}); q1.push_back({1'b0, 8'h52}); q1.push_back({1'b1, 8'h53});
    wait_got("ar", 1, 20);
    chk("ar_pre_gnt", 32'(arb_gnt), 32'(2'b10));
    chk("ar_pre_rdy1", 32'(req1_rdy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(arb_gnt), 0);
    chk("ar_vld", 32'(uart_vld), 0);
    chk("ar_rdy1", 32'(req1_rdy), 0);
    q0.delete();
    q1.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    clear_got();
    q0.push_back({1'b1, 8'h61});
    q1.push_back({1'b1, 8'h71});
    wait_got("post", 2, 20);
    chk_got("post0", 0, 8'h61, 2'b01);
    chk_got("post1", 1, 8'h71, 2'b10);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-requester arbiter that shares the single `uart_tx` byte channel between the RAM loader (`ram_rw`) and a CPU console port. It sits between the requesters and `uart_tx`. Each requester gets exclusive use of the channel for a whole burst, delimited by a `last` flag. Grants alternate round-robin between bursts, and an idle timeout reclaims the channel from a stalled requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, consecutive grant cycles with requester `vld` low before the grant is revoked; legal range 1..65535.

Ports:
- clk_i  input  1  system clock (`sys_clk`)
- rst_n_i  input  1  reset; asynchronous, active-low (`sys_rst_n`)
- req0_data_i  input  8  requester 0 (loader) byte
- req0_data_vld_i  input  1  requester 0 byte valid
- req0_data_last_i  input  1  byte is last of requester 0 burst
- req0_data_rdy_o  output  1  requester 0 byte accepted this cycle when `vld` is also high
- req1_data_i  input  8  requester 1 (CPU console) byte
- req1_data_vld_i  input  1  requester 1 byte valid
- req1_data_last_i  input  1  byte is last of requester 1 burst
- req1_data_rdy_o  output  1  requester 1 byte accepted this cycle when `vld` is also high
- uart_tx_data_o  output  8  byte to `uart_tx`
- uart_tx_data_vld_o  output  1  byte valid to `uart_tx`
- uart_tx_data_rdy_i  input  1  `uart_tx` ready
- arb_gnt_o  output  2  one-hot grant; bit n means requester n owns the channel
- arb_timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- A transfer occurs on a rising edge where `vld` and `rdy` are both high, on either side of the arbiter.
- States:
  - IDLE
  - GNT0
  - GNT1
- Round-robin pointer `last_gnt`:
  - Reset value is 1, so requester 0 wins the first tie.
  - It is updated to n whenever GNTn is exited, by `last` or by timeout.
- IDLE transitions:
  - Only req0_vld high -> GNT0.
  - Only req1_vld high -> GNT1.
  - Both high -> grant goes to the requester that is not `last_gnt`.
  - Neither high -> stay in IDLE.
- GNTn is a combinational pass-through:
  - `uart_tx_data_o` = reqn_data.
  - `uart_tx_data_vld_o` = reqn_vld.
  - reqn_rdy = `uart_tx_data_rdy_i`.
  - The other requester's rdy = 0.
- GNTn exits:
  - A transfer with reqn_last = 1 -> IDLE.
  - A timeout -> IDLE, and `arb_timeout_o` pulses for that cycle.
- Idle counter (width $clog2(TIMEOUT_CYCLES+1)):
  - Cleared in IDLE.
  - Cleared on every GNTn cycle where reqn_vld = 1.
  - Incremented otherwise.
  - Timeout fires in the cycle where the counter equals TIMEOUT_CYCLES-1 and reqn_vld = 0.
- In IDLE: `uart_tx_data_o` = 0, `uart_tx_data_vld_o` = 0, both rdy = 0.
- `arb_gnt_o` = {state==GNT1, state==GNT0}.
- A requester must not drop `vld` or change data/`last` while `vld`=1 and `rdy`=0. The arbiter does not check this; the bench asserts it as an environment assumption.
- `uart_tx_data_rdy_i` is ignored in IDLE.

## Timing
- Reset values:
  - state IDLE, `last_gnt` = 1, counter = 0.
  - All outputs 0: `arb_gnt_o` = 2'b00, `arb_timeout_o` = 0, rdy/vld/data = 0.
- Grant latency: `vld` sampled high in IDLE at edge k puts the block in GNTn after edge k. The first byte may transfer at edge k+1.
- Data path adds zero cycles: vld, data and rdy pass combinationally while granted.
- A burst ends on its `last` transfer at edge m. The block is in IDLE during cycle m+1, so there is at least one IDLE cycle between bursts.
- The next grant takes effect after edge m+1.
- Single-byte burst: `last` on the first byte; GNTn lasts exactly one accepted transfer.
- Simultaneous events:
  - Requesters that assert `vld` while the other is granted wait with rdy = 0.
  - `last` transfer and timeout cannot coincide, because timeout requires `vld` = 0.
- Timeout and `vld`: with TIMEOUT_CYCLES = T, if reqn_vld stays low for T consecutive GNTn cycles, the block is in IDLE after the T-th edge.
- Reset mid-burst: the arbiter returns to IDLE and drops grant immediately (asynchronously); `uart_tx` sees vld fall.
- Counter saturation is impossible: exit occurs at TIMEOUT_CYCLES.

## Test plan
- Reset then idle 10 cycles: all outputs 0, `arb_gnt_o` = 00.
- Burst ownership: req0 sends 4 bytes 0x11..0x14 with `last` on 0x14, while req1 holds `vld` with 0xA5 from cycle 2.
  - `uart_tx` receives 11,12,13,14 then A5.
  - `req1_rdy` stays 0 until GNT1.
  - Exactly one IDLE cycle separates the bursts.
- Round-robin fairness: both requesters continuously issue single-byte bursts (`last` = 1) with data 0x0n and 0x1n.
  - Output alternates 00,10,01,11,...
  - The first grant goes to req0.
- Back-pressure: `uart_tx_data_rdy_i` low for 107 cycles per byte during a 3-byte req1 burst.
  - Each byte is held stable.
  - No duplication or loss.
  - `arb_gnt_o` = 10 throughout.
- Timeout with TIMEOUT_CYCLES = 8: req0 sends 1 byte without `last`, then drops `vld`.
  - `arb_timeout_o` pulses once, 8 cycles after the last `vld`-high cycle.
  - Pending req1 is granted next.
- Async reset asserted mid-burst in GNT1: `arb_gnt_o`, `uart_tx_data_vld_o` and `req1_data_rdy_o` go to 0 without waiting for a clock edge. After release, req0 wins the first tie.
